// File: rtl/trade_uart_tx.sv
// Trade-report UART transmitter: buffers {price, bid, ask} records and sends each
// as a 5-byte 8N1 frame (sync, price, bid, ask, checksum) on a single TX pin.
`timescale 1ns/1ps
module trade_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        trade_valid,
  input  logic [7:0]                  trade_price,
  input  logic [7:0]                  best_bid,
  input  logic [7:0]                  best_ask,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CLK_ONE   = CW'(1);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  function automatic logic [7:0] frame_checksum(input logic [23:0] rec);
    return rec[23:16] ^ rec[15:8] ^ rec[7:0];
  endfunction

  state_t        state_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [2:0]    byte_idx_q;
  logic [23:0]   rec_q;
  logic [7:0]    chk_q;
  logic          txd_q;
  logic          busy_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [7:0]    drop_q;
  logic [23:0]   mem_q [FIFO_DEPTH];

  logic       pop_s;
  logic       full_s;
  logic       push_s;
  logic       drop_s;
  logic       bit_end_s;
  logic [7:0] byte_s;

  // A pop while full frees the slot the same edge, so the push still lands.
  assign pop_s     = (state_q == IDLE) && (count_q != {(AW+1){1'b0}});
  assign full_s    = (count_q == FULL_CNT);
  assign push_s    = trade_valid && (!full_s || pop_s);
  assign drop_s    = trade_valid && full_s && !pop_s;
  assign bit_end_s = (clk_cnt_q == LAST_CLK);

  // Byte currently on the wire, selected by frame position.
  always_comb begin
    byte_s = SYNC_BYTE;
    case (byte_idx_q)
      3'd0:    byte_s = SYNC_BYTE;
      3'd1:    byte_s = rec_q[23:16];
      3'd2:    byte_s = rec_q[15:8];
      3'd3:    byte_s = rec_q[7:0];
      3'd4:    byte_s = chk_q;
      default: byte_s = SYNC_BYTE;
    endcase
  end

  // Next FIFO occupancy from push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Record storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {trade_price, best_bid, best_ask};
    end
  end

  // FIFO pointers, occupancy and saturating overflow counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      drop_q   <= 8'd0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
      if (drop_s && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Serializer FSM with registered line and busy outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= {CW{1'b0}};
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      rec_q      <= 24'd0;
      chk_q      <= 8'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clk_cnt_q <= {CW{1'b0}};
          if (pop_s) begin
            rec_q      <= mem_q[rd_ptr_q];
            chk_q      <= frame_checksum(mem_q[rd_ptr_q]);
            byte_idx_q <= 3'd0;
            bit_idx_q  <= 3'd0;
            state_q    <= START;
            txd_q      <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            clk_cnt_q <= {CW{1'b0}};
            bit_idx_q <= 3'd0;
            state_q   <= DATA;
            txd_q     <= byte_s[0];
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_ONE;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            clk_cnt_q <= {CW{1'b0}};
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= byte_s[bit_idx_q + 3'd1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_ONE;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            clk_cnt_q <= {CW{1'b0}};
            if (byte_idx_q < 3'd4) begin
              byte_idx_q <= byte_idx_q + 3'd1;
              state_q    <= START;
              txd_q      <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CLK_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = busy_q;
  assign fifo_count = count_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_trade_uart_tx.sv
// Directed bench for trade_uart_tx: a line monitor decodes 8N1 bytes and busy/idle
// run lengths, and the main sequence compares them with hand-computed frames.
`timescale 1ns/1ps
module tb_trade_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       trade_valid = 1'b0;
  logic [7:0] trade_price = 8'd0;
  logic [7:0] best_bid = 8'd0;
  logic [7:0] best_ask = 8'd0;
  logic       uart_txd;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;

  int checks = 0;
  int failures = 0;

  trade_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .trade_valid(trade_valid),
    .trade_price(trade_price), .best_bid(best_bid), .best_ask(best_ask),
    .uart_txd(uart_txd), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Line monitor state: decoded bytes, framing errors, busy and gap run lengths.
  logic [7:0] rx_q [$];
  int         busy_q [$];
  int         gap_q [$];
  logic       rx_active = 1'b0;
  logic [7:0] ph = 8'd0;
  logic [7:0] sh = 8'd0;
  int         rx_bad = 0;
  int         brun = 0;
  int         grun = 0;
  logic       have_busy = 1'b0;

  // Mid-bit sampling decoder: start detected at offset 0, bit i sampled at 6+4i.
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_active <= 1'b0;
      ph        <= 8'd0;
      brun      <= 0;
      grun      <= 0;
      have_busy <= 1'b0;
    end else begin
      if (tx_busy) begin
        if (brun == 0 && have_busy) gap_q.push_back(grun);
        brun <= brun + 1;
        grun <= 0;
      end else begin
        if (brun != 0) begin
          busy_q.push_back(brun);
          have_busy <= 1'b1;
        end
        brun <= 0;
        grun <= grun + 1;
      end
      if (!rx_active) begin
        if (!uart_txd) begin
          rx_active <= 1'b1;
          ph        <= 8'd1;
        end
      end else begin
        ph <= ph + 8'd1;
        if (ph == 8'd2 && uart_txd) rx_bad <= rx_bad + 1;
        if (ph >= 8'd6 && ph <= 8'd34 && ph[1:0] == 2'd2) sh <= {uart_txd, sh[7:1]};
        if (ph == 8'd38) begin
          if (uart_txd) rx_q.push_back(sh);
          else rx_bad <= rx_bad + 1;
        end
        if (ph == 8'd39) rx_active <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rx(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && rx_q.size() < target; i++) step(1);
    chk(tag, 32'(rx_q.size()), 32'(target));
  endtask

  task automatic chk_frame(input string tag, input int base,
                           input logic [7:0] p, input logic [7:0] b,
                           input logic [7:0] a, input logic [7:0] c);
    logic [7:0] exp [5];
    exp[0] = 8'hA5; exp[1] = p; exp[2] = b; exp[3] = a; exp[4] = c;
    for (int j = 0; j < 5; j++)
      chk($sformatf("%s_byte%0d", tag, j), 32'(rx_q[base + j]), 32'(exp[j]));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && tx_busy; i++) step(1);
  endtask

  initial begin
    int rb;
    int bb;
    int gb;
    int peak;

    reset_n = 1'b0;
    step(3);
    chk("reset_txd", 32'(uart_txd), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    step(3);

    // Single trade: start bit two edges after capture, busy for 50 bit times.
    rb = rx_q.size();
    bb = busy_q.size();
    trade_price = 8'h3C; best_bid = 8'h3E; best_ask = 8'h3A; trade_valid = 1'b1;
    step(1);
    trade_valid = 1'b0;
    chk("cap_count", 32'(fifo_count), 32'd1);
    chk("cap_txd_idle", 32'(uart_txd), 32'd1);
    chk("cap_busy_low", 32'(tx_busy), 32'd0);
    step(1);
    chk("start_txd", 32'(uart_txd), 32'd0);
    chk("start_busy", 32'(tx_busy), 32'd1);
    chk("start_count", 32'(fifo_count), 32'd0);
    wait_rx("single_rx", rb + 5, 300);
    chk_frame("single", rb, 8'h3C, 8'h3E, 8'h3A, 8'h38);
    for (int i = 0; i < 50 && busy_q.size() <= bb; i++) step(1);
    chk("single_busy_runs", 32'(busy_q.size()), 32'(bb + 1));
    if (busy_q.size() > bb) chk("single_busy_len", 32'(busy_q[bb]), 32'd200);
    step(5);

    // Burst of 6 consecutive pulses: one overflow, five frames in order.
    rb = rx_q.size();
    gb = gap_q.size();
    peak = 0;
    for (int i = 0; i < 6; i++) begin
      trade_price = 8'(8'h10 + i); best_bid = 8'(8'h20 + i); best_ask = 8'(8'h30 + i);
      trade_valid = 1'b1;
      step(1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    trade_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    chk("burst_peak", 32'(peak), 32'd4);
    chk("burst_drop", 32'(drop_count), 32'd1);
    wait_rx("burst_rx", rb + 25, 1200);
    for (int f = 0; f < 5; f++) begin
      logic [7:0] p, b, a;
      p = 8'(8'h10 + f); b = 8'(8'h20 + f); a = 8'(8'h30 + f);
      chk_frame($sformatf("burst_f%0d", f), rb + 5 * f, p, b, a, p ^ b ^ a);
    end
    chk("burst_gaps", 32'(gap_q.size()), 32'(gb + 5));
    for (int j = 1; j < 5; j++)
      if (gap_q.size() > gb + j) chk($sformatf("burst_gap%0d", j), 32'(gap_q[gb + j]), 32'd1);
    wait_idle(100);
    step(3);

    // Full FIFO with a push on the pop edge: push accepted, count holds at 4.
    rb = rx_q.size();
    for (int i = 0; i < 5; i++) begin
      trade_price = 8'(8'h50 + i); best_bid = 8'(8'h60 + i); best_ask = 8'(8'h70 + i);
      trade_valid = 1'b1;
      step(1);
    end
    trade_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 32'd4);
    wait_idle(400);
    chk("full_idle_slot", 32'(tx_busy), 32'd0);
    trade_price = 8'h55; best_bid = 8'h65; best_ask = 8'h75; trade_valid = 1'b1;
    step(1);
    trade_valid = 1'b0;
    chk("full_pop_count", 32'(fifo_count), 32'd4);
    chk("full_pop_drop", 32'(drop_count), 32'd1);
    chk("full_pop_busy", 32'(tx_busy), 32'd1);
    wait_rx("full_rx", rb + 30, 1400);
    for (int f = 0; f < 6; f++) begin
      logic [7:0] p, b, a;
      p = 8'(8'h50 + f); b = 8'(8'h60 + f); a = 8'(8'h70 + f);
      chk_frame($sformatf("full_f%0d", f), rb + 5 * f, p, b, a, p ^ b ^ a);
    end
    wait_idle(300);
    step(3);

    // Reset during DATA of byte 2 (bid 0x00 keeps the line low there).
    trade_price = 8'h11; best_bid = 8'h00; best_ask = 8'h33; trade_valid = 1'b1;
    step(1);
    trade_valid = 1'b0;
    for (int i = 0; i < 10 && uart_txd; i++) step(1);
    chk("mr_start_seen", 32'(uart_txd), 32'd0);
    step(10);
    trade_price = 8'h44; best_bid = 8'h45; best_ask = 8'h46; trade_valid = 1'b1;
    step(1);
    trade_price = 8'h54; best_bid = 8'h55; best_ask = 8'h56;
    step(1);
    trade_valid = 1'b0;
    step(78);
    chk("mr_pre_count", 32'(fifo_count), 32'd2);
    chk("mr_pre_txd", 32'(uart_txd), 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("mr_txd", 32'(uart_txd), 32'd1);
    chk("mr_busy", 32'(tx_busy), 32'd0);
    chk("mr_count", 32'(fifo_count), 32'd0);
    chk("mr_drop", 32'(drop_count), 32'd0);
    step(2);
    reset_n = 1'b1;
    rb = rx_q.size();
    bb = busy_q.size();
    step(400);
    chk("mr_no_rx", 32'(rx_q.size()), 32'(rb));
    chk("mr_no_busy_runs", 32'(busy_q.size()), 32'(bb));
    chk("mr_idle_busy", 32'(tx_busy), 32'd0);
    chk("mr_idle_txd", 32'(uart_txd), 32'd1);

    // Saturation: continuous pulses; edges 5..99 overflow, later ones saturate.
    trade_price = 8'h01; best_bid = 8'h02; best_ask = 8'h03; trade_valid = 1'b1;
    step(100);
    chk("sat_drop_95", 32'(drop_count), 32'd95);
    step(300);
    trade_valid = 1'b0;
    chk("sat_drop_255", 32'(drop_count), 32'd255);
    step(2);
    chk("sat_drop_hold", 32'(drop_count), 32'd255);
    reset_n = 1'b0;
    step(2);
    chk("sat_reset_drop", 32'(drop_count), 32'd0);
    reset_n = 1'b1;
    step(3);

    // Input isolation: buses churn every cycle after each capture.
    rb = rx_q.size();
    trade_price = 8'h9A; best_bid = 8'hBC; best_ask = 8'hDE; trade_valid = 1'b1;
    step(1);
    for (int c = 0; c < 500; c++) begin
      if (c == 60) begin
        trade_price = 8'h01; best_bid = 8'h80; best_ask = 8'h7F; trade_valid = 1'b1;
      end else begin
        trade_valid = 1'b0;
        trade_price = 8'($urandom_range(0, 255));
        best_bid    = 8'($urandom_range(0, 255));
        best_ask    = 8'($urandom_range(0, 255));
      end
      step(1);
    end
    trade_valid = 1'b0;
    wait_rx("iso_rx", rb + 10, 400);
    chk_frame("iso_f0", rb, 8'h9A, 8'hBC, 8'hDE, 8'hF8);
    chk_frame("iso_f1", rb + 5, 8'h01, 8'h80, 8'h7F, 8'hFE);
    chk("framing_errors", 32'(rx_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
